// File: rtl/varredura_x_pkg.sv
// Shared definitions for the varredura_x sweep sequencer: FSM states,
// operand/entry widths and the bit layout of a FIFO entry.
package varredura_x_pkg;

    localparam int LARG_DADO    = 16;
    localparam int LARG_ENTRADA = 33;

    // Entry layout: {ovf, x[15:0], res[15:0]}
    localparam int POS_RES = 0;
    localparam int POS_X   = 16;
    localparam int POS_OVF = 32;

    typedef enum logic [2:0] {
        OCIOSO,
        DISPARA,
        AGUARDA_OCUPADO,
        AGUARDA_PRONTO,
        GRAVA,
        FIM
    } estado_t;

    function automatic logic [LARG_ENTRADA-1:0] monta_entrada(
        input logic                 ovf,
        input logic [LARG_DADO-1:0] x,
        input logic [LARG_DADO-1:0] res
    );
        logic [LARG_ENTRADA-1:0] e;
        e                        = '0;
        e[POS_OVF]               = ovf;
        e[POS_X +: LARG_DADO]    = x;
        e[POS_RES +: LARG_DADO]  = res;
        return e;
    endfunction

endpackage

// File: rtl/varredura_x_if.sv
// Evaluator-side bus of varredura_x: start pulse and operands out,
// done level, overflow and result back.
interface varredura_x_if;
    import varredura_x_pkg::*;

    logic                 inicio;
    logic [LARG_DADO-1:0] X;
    logic [LARG_DADO-1:0] A;
    logic [LARG_DADO-1:0] B;
    logic [LARG_DADO-1:0] C;
    logic                 pronto;
    logic                 overflow;
    logic [LARG_DADO-1:0] resultado;

    // Sequencer side
    modport master (
        output inicio, X, A, B, C,
        input  pronto, overflow, resultado
    );

    // Evaluator side
    modport slave (
        input  inicio, X, A, B, C,
        output pronto, overflow, resultado
    );

endinterface

// File: rtl/varredura_x_fifo_resultados.sv
// Synchronous result FIFO with a registered head entry. The head register
// keeps its last value while the FIFO is empty. Pops on empty and pushes on
// full are dropped; simultaneous push and pop are both honoured.
module fifo_resultados
    import varredura_x_pkg::*;
#(
    parameter int PROF = 8,
    parameter int LARG = LARG_ENTRADA
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [LARG-1:0]           entrada_i,
    input  logic                      pop_i,
    output logic [LARG-1:0]           cabeca_o,
    output logic [$clog2(PROF):0]     contagem_o,
    output logic                      vazio_o,
    output logic                      cheio_o
);

    localparam int                LARG_PTR   = $clog2(PROF);
    localparam logic [LARG_PTR:0] CONT_CHEIO = (LARG_PTR+1)'(PROF);
    localparam logic [LARG_PTR:0] CONT_UM    = (LARG_PTR+1)'(1);

    logic [LARG-1:0]     mem_q [PROF];
    logic [LARG_PTR-1:0] rd_q, rd_d;
    logic [LARG_PTR-1:0] wr_q, wr_d;
    logic [LARG_PTR:0]   cont_q, cont_d;
    logic [LARG-1:0]     cabeca_q, cabeca_d;
    logic                push_ef;
    logic                pop_ef;

    // Pointer/count update and selection of the next head entry
    always_comb begin
        pop_ef   = pop_i && (cont_q != '0);
        push_ef  = push_i && (cont_q != CONT_CHEIO);
        rd_d     = rd_q;
        wr_d     = wr_q;
        cont_d   = cont_q;
        cabeca_d = cabeca_q;
        if (pop_ef) begin
            rd_d = rd_q + LARG_PTR'(1);
        end
        if (push_ef) begin
            wr_d = wr_q + LARG_PTR'(1);
        end
        case ({push_ef, pop_ef})
            2'b10:   cont_d = cont_q + CONT_UM;
            2'b01:   cont_d = cont_q - CONT_UM;
            default: cont_d = cont_q;
        endcase
        // When the FIFO was (or becomes after the pop) empty, the new head
        // is the entry being pushed; otherwise it is already in memory.
        if (cont_d != '0) begin
            if (cont_q == '0 || (pop_ef && cont_q == CONT_UM)) begin
                cabeca_d = entrada_i;
            end else begin
                cabeca_d = mem_q[rd_d];
            end
        end
    end

    // Entry storage, written on accepted pushes
    always_ff @(posedge ck) begin
        if (push_ef) begin
            mem_q[wr_q] <= entrada_i;
        end
    end

    // Pointers, count and head register
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            rd_q     <= '0;
            wr_q     <= '0;
            cont_q   <= '0;
            cabeca_q <= '0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cont_q   <= cont_d;
            cabeca_q <= cabeca_d;
        end
    end

    assign cabeca_o   = cabeca_q;
    assign contagem_o = cont_q;
    assign vazio_o    = (cont_q == '0);
    assign cheio_o    = (cont_q == CONT_CHEIO);

endmodule

// File: rtl/varredura_x.sv
// varredura_x: sweeps X from x_ini in steps of passo, issues one evaluator
// job per point and stores {ovf, X, resultado} in a result FIFO drained by
// the host through dado_valido/ler.
// Build option: define PARA_OVERFLOW_EN to end the sweep right after the
// first entry captured with overflow set.
module varredura_x
    import varredura_x_pkg::*;
#(
    parameter int PROF    = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    comecar,
    input  logic [LARG_DADO-1:0]    x_ini,
    input  logic [LARG_DADO-1:0]    passo,
    input  logic [7:0]              n_pontos,
    input  logic [LARG_DADO-1:0]    coef_a,
    input  logic [LARG_DADO-1:0]    coef_b,
    input  logic [LARG_DADO-1:0]    coef_c,
    varredura_x_if.master           av,
    output logic                    ocupado,
    output logic                    fim,
    output logic                    erro,
    output logic                    dado_valido,
    output logic [LARG_ENTRADA-1:0] dado,
    input  logic                    ler
);

    localparam int                      LARG_CONT    = $clog2(PROF) + 1;
    localparam logic [LARG_CONT-1:0]    CONT_PROF    = LARG_CONT'(PROF);
    localparam int                      LARG_TEMPO   = $clog2(TIMEOUT + 1);
    localparam logic [LARG_TEMPO-1:0]   TEMPO_LIMITE = LARG_TEMPO'(TIMEOUT - 1);

    estado_t                 estado_q, estado_d;
    logic [LARG_DADO-1:0]    x_q, x_d;
    logic [LARG_DADO-1:0]    a_q, a_d;
    logic [LARG_DADO-1:0]    b_q, b_d;
    logic [LARG_DADO-1:0]    c_q, c_d;
    logic [LARG_DADO-1:0]    passo_q, passo_d;
    logic [7:0]              restantes_q, restantes_d;
    logic [LARG_TEMPO-1:0]   tempo_q, tempo_d;
    logic [LARG_ENTRADA-1:0] cap_q, cap_d;
    logic                    erro_q, erro_d;

    logic                    grava;
    logic                    fifo_push;
    logic [LARG_CONT-1:0]    fifo_cont;
    logic                    fifo_vazio;
    logic                    fifo_cheio;
    logic                    expirou;

    assign expirou = (tempo_q == TEMPO_LIMITE);

    // Next-state and control outputs of the sweep FSM
    always_comb begin
        estado_d    = estado_q;
        x_d         = x_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        passo_d     = passo_q;
        restantes_d = restantes_q;
        tempo_d     = tempo_q;
        cap_d       = cap_q;
        erro_d      = erro_q;
        grava       = 1'b0;
        av.inicio   = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (comecar) begin
                    x_d         = x_ini;
                    a_d         = coef_a;
                    b_d         = coef_b;
                    c_d         = coef_c;
                    passo_d     = passo;
                    restantes_d = n_pontos;
                    erro_d      = 1'b0;
                    estado_d    = (n_pontos == 8'd0) ? FIM : DISPARA;
                end
            end

            DISPARA: begin
                tempo_d = '0;
                // No job is in flight here, so the FIFO level alone
                // decides whether the next result would still fit.
                if (fifo_cont != CONT_PROF) begin
                    av.inicio = 1'b1;
                    estado_d  = AGUARDA_OCUPADO;
                end
            end

            AGUARDA_OCUPADO: begin
                tempo_d = tempo_q + LARG_TEMPO'(1);
                // A pronto still high from the previous job is not completion.
                if (!av.pronto) begin
                    estado_d = AGUARDA_PRONTO;
                end else if (expirou) begin
                    erro_d   = 1'b1;
                    estado_d = FIM;
                end
            end

            AGUARDA_PRONTO: begin
                tempo_d = tempo_q + LARG_TEMPO'(1);
                if (av.pronto) begin
                    cap_d    = monta_entrada(av.overflow, x_q, av.resultado);
                    estado_d = GRAVA;
                end else if (expirou) begin
                    erro_d   = 1'b1;
                    estado_d = FIM;
                end
            end

            GRAVA: begin
                grava       = 1'b1;
                x_d         = x_q + passo_q;
                restantes_d = restantes_q - 8'd1;
                if (restantes_q == 8'd1) begin
                    estado_d = FIM;
                end else begin
                    estado_d = DISPARA;
                end
`ifdef PARA_OVERFLOW_EN
                if (cap_q[POS_OVF]) begin
                    estado_d = FIM;
                end
`endif
            end

            FIM: begin
                estado_d = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Sweep state and operand registers
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            estado_q    <= OCIOSO;
            x_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            passo_q     <= '0;
            restantes_q <= '0;
            tempo_q     <= '0;
            cap_q       <= '0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            x_q         <= x_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            passo_q     <= passo_d;
            restantes_q <= restantes_d;
            tempo_q     <= tempo_d;
            cap_q       <= cap_d;
            erro_q      <= erro_d;
        end
    end

    // DISPARA never fires into a full FIFO; the guard keeps the push
    // request honest even so.
    assign fifo_push = grava && !fifo_cheio;

    fifo_resultados #(
        .PROF (PROF),
        .LARG (LARG_ENTRADA)
    ) u_fifo (
        .ck         (ck),
        .rst        (rst),
        .push_i     (fifo_push),
        .entrada_i  (cap_q),
        .pop_i      (ler),
        .cabeca_o   (dado),
        .contagem_o (fifo_cont),
        .vazio_o    (fifo_vazio),
        .cheio_o    (fifo_cheio)
    );

    assign av.X        = x_q;
    assign av.A        = a_q;
    assign av.B        = b_q;
    assign av.C        = c_q;
    assign ocupado     = (estado_q != OCIOSO) && (estado_q != FIM);
    assign fim         = (estado_q == FIM);
    assign erro        = erro_q;
    assign dado_valido = !fifo_vazio;

endmodule

// File: tb/tb_varredura_x.sv
// Bench for varredura_x: behavioural polynomial evaluator, host reader,
// vector table with hand-computed results, corner-case sequences and
// randomized sweeps checked against a queue-based reference model.
module tb_varredura_x;
    import varredura_x_pkg::*;

    localparam int PROF    = 8;
    localparam int TIMEOUT = 1023;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        comecar = 1'b0;
    logic [15:0] x_ini = '0, passo = '0;
    logic [7:0]  n_pontos = '0;
    logic [15:0] coef_a = '0, coef_b = '0, coef_c = '0;
    logic        ocupado, fim, erro, dado_valido;
    logic [32:0] dado;
    logic        ler;

    varredura_x_if ifc ();

    varredura_x #(.PROF(PROF), .TIMEOUT(TIMEOUT)) dut (
        .ck          (ck),
        .rst         (rst),
        .comecar     (comecar),
        .x_ini       (x_ini),
        .passo       (passo),
        .n_pontos    (n_pontos),
        .coef_a      (coef_a),
        .coef_b      (coef_b),
        .coef_c      (coef_c),
        .av          (ifc),
        .ocupado     (ocupado),
        .fim         (fim),
        .erro        (erro),
        .dado_valido (dado_valido),
        .dado        (dado),
        .ler         (ler)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;

    task automatic confere(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
        end
    endtask

    function automatic logic [63:0] poli(input logic [15:0] a, input logic [15:0] x,
                                         input logic [15:0] b, input logic [15:0] c);
        return 64'(a) * 64'(x) * 64'(x) + 64'(b) * 64'(x) + 64'(c);
    endfunction

    // Evaluator model: drops pronto after inicio, answers after a latency
    bit mudo     = 1'b0;
    int lat_fixa = 0;
    initial begin
        ifc.pronto    = 1'b1;
        ifc.overflow  = 1'b0;
        ifc.resultado = '0;
        forever begin
            @(negedge ck);
            if (ifc.inicio === 1'b1) begin
                logic [63:0] res_total;
                int          lat;
                res_total = poli(ifc.A, ifc.X, ifc.B, ifc.C);
                lat = (lat_fixa != 0) ? lat_fixa : int'($urandom_range(4, 1));
                @(posedge ck);
                #1 ifc.pronto = 1'b0;
                if (!mudo) begin
                    repeat (lat) @(posedge ck);
                    #1;
                    ifc.resultado = res_total[15:0];
                    ifc.overflow  = (res_total > 64'hFFFF);
                    ifc.pronto    = 1'b1;
                end
            end
        end
    end

    // Pulse counters
    int n_inicio = 0;
    int n_fim    = 0;
    initial forever begin
        @(negedge ck);
        if (ifc.inicio === 1'b1) n_inicio++;
        if (fim === 1'b1) n_fim++;
    end

    // Host reader: random or counted pops, records every popped entry
    int          ler_prob  = 0;
    int          pops_pend = 0;
    logic [32:0] recebidos[$];
    initial begin
        ler = 1'b0;
        forever begin
            @(negedge ck);
            if (rst && dado_valido === 1'b1 &&
                (pops_pend > 0 || (ler_prob > 0 && int'($urandom_range(99, 0)) < ler_prob))) begin
                recebidos.push_back(dado);
                ler = 1'b1;
                if (pops_pend > 0) pops_pend--;
            end else begin
                ler = 1'b0;
            end
        end
    end

    // Reference model: the list of entries a sweep must produce
    logic [32:0] esperados[$];
    task automatic gera_modelo(input logic [15:0] x0, input logic [15:0] p, input int n,
                               input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        esperados.delete();
        for (int i = 0; i < n; i++) begin
            logic [15:0] x;
            logic [63:0] r;
            x = 16'(32'(x0) + 32'(i) * 32'(p));
            r = poli(a, x, b, c);
            esperados.push_back({(r > 64'hFFFF), x, r[15:0]});
`ifdef PARA_OVERFLOW_EN
            if (r > 64'hFFFF) break;
`endif
        end
    endtask

    task automatic dispara(input logic [15:0] x0, input logic [15:0] p, input logic [7:0] n,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        @(negedge ck);
        x_ini = x0; passo = p; n_pontos = n;
        coef_a = a; coef_b = b; coef_c = c;
        comecar = 1'b1;
        @(negedge ck);
        comecar = 1'b0;
    endtask

    task automatic espera_fim(input string nome, input int limite);
        int k = 0;
        while (fim !== 1'b1 && k < limite) begin
            @(negedge ck);
            k++;
        end
        confere({nome, " fim"}, 64'(fim), 64'(1));
        confere({nome, " ocupado@fim"}, 64'(ocupado), 64'(0));
    endtask

    task automatic drena(input string nome, input int limite);
        int k = 0;
        ler_prob = 100;
        while (dado_valido === 1'b1 && k < limite) begin
            @(negedge ck);
            k++;
        end
        ler_prob = 0;
        @(negedge ck);
        confere({nome, " drained"}, 64'(dado_valido), 64'(0));
    endtask

    task automatic compara(input string nome);
        int m;
        confere({nome, " entries"}, 64'(recebidos.size()), 64'(esperados.size()));
        m = (recebidos.size() < esperados.size()) ? recebidos.size() : esperados.size();
        for (int i = 0; i < m; i++) begin
            confere($sformatf("%s entry[%0d]", nome, i), 64'(recebidos[i]), 64'(esperados[i]));
        end
    endtask

    typedef struct {
        logic [15:0] x0;
        logic [15:0] p;
        logic [7:0]  n;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        int          n_ent;
        logic [32:0] ultima;
    } vetor_t;

    vetor_t tab[7];

    initial begin
        int i0, f0, k, d;

        tab[0] = '{16'h0000, 16'h0001, 8'd3, 16'h0001, 16'h0002, 16'h0003, 3, {1'b0, 16'h0002, 16'h000B}};
        tab[1] = '{16'hFFFF, 16'h0001, 8'd2, 16'h0000, 16'h0001, 16'h0000, 2, {1'b0, 16'h0000, 16'h0000}};
`ifdef PARA_OVERFLOW_EN
        tab[2] = '{16'h0100, 16'h0001, 8'd4, 16'h0100, 16'h0000, 16'h0000, 1, {1'b1, 16'h0100, 16'h0000}};
        tab[6] = '{16'h00F0, 16'h0001, 8'd2, 16'h0003, 16'h0000, 16'h0000, 1, {1'b1, 16'h00F0, 16'hA300}};
`else
        tab[2] = '{16'h0100, 16'h0001, 8'd4, 16'h0100, 16'h0000, 16'h0000, 4, {1'b1, 16'h0103, 16'h0900}};
        tab[6] = '{16'h00F0, 16'h0001, 8'd2, 16'h0003, 16'h0000, 16'h0000, 2, {1'b1, 16'h00F1, 16'hA8A3}};
`endif
        tab[3] = '{16'h0000, 16'h0001, 8'd0, 16'h0001, 16'h0001, 16'h0001, 0, 33'h0};
        tab[4] = '{16'h0005, 16'h0003, 8'd5, 16'h0000, 16'h0000, 16'h0007, 5, {1'b0, 16'h0011, 16'h0007}};
        tab[5] = '{16'h000A, 16'hFFFE, 8'd4, 16'h0000, 16'h0002, 16'h0001, 4, {1'b0, 16'h0004, 16'h0009}};

        // Reset state
        @(negedge ck);
        confere("rst inicio", 64'(ifc.inicio), 64'(0));
        confere("rst ocupado", 64'(ocupado), 64'(0));
        confere("rst fim", 64'(fim), 64'(0));
        confere("rst erro", 64'(erro), 64'(0));
        confere("rst dado_valido", 64'(dado_valido), 64'(0));
        confere("rst dado", 64'(dado), 64'(0));
        confere("rst X", 64'(ifc.X), 64'(0));
        rst = 1'b1;
        repeat (2) @(negedge ck);

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            recebidos.delete();
            gera_modelo(tab[v].x0, tab[v].p, int'(tab[v].n), tab[v].a, tab[v].b, tab[v].c);
            i0 = n_inicio; f0 = n_fim;
            dispara(tab[v].x0, tab[v].p, tab[v].n, tab[v].a, tab[v].b, tab[v].c);
            espera_fim(nm, 200);
            repeat (3) @(negedge ck);
            confere({nm, " fim pulses"}, 64'(n_fim - f0), 64'(1));
            confere({nm, " inicio pulses"}, 64'(n_inicio - i0), 64'(tab[v].n_ent));
            confere({nm, " erro"}, 64'(erro), 64'(0));
            drena(nm, 100);
            compara(nm);
            confere({nm, " table count"}, 64'(recebidos.size()), 64'(tab[v].n_ent));
            if (recebidos.size() > 0)
                confere({nm, " table last"}, 64'(recebidos[recebidos.size()-1]), 64'(tab[v].ultima));
        end

        // FIFO back-pressure: 10 points into an 8-deep FIFO, nobody reading
        recebidos.delete();
        gera_modelo(16'h0, 16'h1, 10, 16'h1, 16'h2, 16'h3);
        i0 = n_inicio; f0 = n_fim;
        dispara(16'h0, 16'h1, 8'd10, 16'h1, 16'h2, 16'h3);
        k = 0;
        while (n_inicio - i0 < 8 && k < 500) begin @(negedge ck); k++; end
        repeat (40) @(negedge ck);
        confere("stall inicio pulses", 64'(n_inicio - i0), 64'(8));
        confere("stall ocupado", 64'(ocupado), 64'(1));
        confere("stall no fim", 64'(n_fim - f0), 64'(0));
        confere("stall dado_valido", 64'(dado_valido), 64'(1));
        pops_pend = 2;
        espera_fim("stall", 300);
        repeat (3) @(negedge ck);
        confere("stall total inicio", 64'(n_inicio - i0), 64'(10));
        confere("stall fim pulses", 64'(n_fim - f0), 64'(1));
        drena("stall", 100);
        compara("stall");

        // Evaluator never answers
        mudo = 1'b1;
        recebidos.delete();
        i0 = n_inicio; f0 = n_fim;
        dispara(16'h0, 16'h1, 8'd3, 16'h1, 16'h1, 16'h1);
        k = 0;
        while (ifc.inicio !== 1'b1 && k < 20) begin @(negedge ck); k++; end
        d = 0;
        while (erro !== 1'b1 && d < TIMEOUT + 10) begin @(negedge ck); d++; end
        confere("timeout window", 64'(d >= TIMEOUT && d <= TIMEOUT + 2), 64'(1));
        confere("timeout fim", 64'(fim), 64'(1));
        repeat (3) @(negedge ck);
        confere("timeout erro sticky", 64'(erro), 64'(1));
        confere("timeout fim pulses", 64'(n_fim - f0), 64'(1));
        confere("timeout inicio pulses", 64'(n_inicio - i0), 64'(1));
        confere("timeout fifo empty", 64'(dado_valido), 64'(0));
        mudo = 1'b0;
        gera_modelo(16'h0007, 16'h1, 1, 16'h0, 16'h0, 16'h5);
        dispara(16'h0007, 16'h1, 8'd1, 16'h0, 16'h0, 16'h5);
        confere("erro cleared", 64'(erro), 64'(0));
        espera_fim("after timeout", 100);
        drena("after timeout", 50);
        compara("after timeout");

        // Reset in the middle of AGUARDA_PRONTO
        lat_fixa = 8;
        recebidos.delete();
        dispara(16'h0, 16'h1, 8'd5, 16'h0, 16'h1, 16'h0);
        k = 0;
        while (dado_valido !== 1'b1 && k < 100) begin @(negedge ck); k++; end
        k = 0;
        while (ifc.inicio !== 1'b1 && k < 100) begin @(negedge ck); k++; end
        repeat (3) @(negedge ck);
        f0 = n_fim;
        rst = 1'b0;
        #1;
        confere("midrst inicio", 64'(ifc.inicio), 64'(0));
        confere("midrst ocupado", 64'(ocupado), 64'(0));
        confere("midrst dado_valido", 64'(dado_valido), 64'(0));
        confere("midrst dado", 64'(dado), 64'(0));
        confere("midrst fim", 64'(fim), 64'(0));
        repeat (2) @(negedge ck);
        rst = 1'b1;
        repeat (15) @(negedge ck);
        confere("midrst no fim", 64'(n_fim - f0), 64'(0));
        confere("midrst idle", 64'(ocupado), 64'(0));
        lat_fixa = 0;
        recebidos.delete();
        gera_modelo(16'h0020, 16'h2, 2, 16'h1, 16'h0, 16'h0);
        dispara(16'h0020, 16'h2, 8'd2, 16'h1, 16'h0, 16'h0);
        espera_fim("post reset", 100);
        drena("post reset", 50);
        compara("post reset");

        // Randomized sweeps with a concurrent random reader
        for (int r = 0; r < 6; r++) begin
            logic [15:0] rx, rp, ra, rb, rc;
            logic [7:0]  rn;
            string       nm;
            nm = $sformatf("rand%0d", r);
            rx = 16'($urandom); rp = 16'($urandom);
            rn = 8'($urandom_range(20, 1));
            ra = 16'($urandom_range(2, 0));
            rb = 16'($urandom_range(255, 0));
            rc = 16'($urandom);
            recebidos.delete();
            gera_modelo(rx, rp, int'(rn), ra, rb, rc);
            f0 = n_fim;
            ler_prob = 40;
            dispara(rx, rp, rn, ra, rb, rc);
            espera_fim(nm, 2000);
            confere({nm, " erro"}, 64'(erro), 64'(0));
            drena(nm, 100);
            confere({nm, " fim pulses"}, 64'(n_fim - f0), 64'(1));
            compara(nm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/varredura_x.md
Name: varredura_x

Overview:
- Initiator-side sequencer for the polynomial evaluator (`inicio`/`pronto` handshake, 16-bit X/A/B/C operands, `resultado` plus `overflow`).
- Sweeps X from `x_ini` in steps of `passo` for `n_pontos` points and issues one evaluation job per point.
- Captures each `{overflow, X, resultado}` into an internal FIFO; the host drains it with a valid/read handshake.

Parameters:
- PROF, 8, FIFO depth in entries; power of two, at least 2.
- TIMEOUT, 1023, maximum cycles spent in either wait state before the `erro` flag is raised.

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- comecar  in  1  one-cycle start-of-sweep request
- x_ini  in  16  first X value, sampled on accepted `comecar`
- passo  in  16  X increment, sampled on accepted `comecar`
- n_pontos  in  8  number of points, sampled on accepted `comecar`
- coef_a, coef_b, coef_c  in  16 each  coefficients, sampled on accepted `comecar`
- inicio  out  1  start pulse to the evaluator
- X, A, B, C  out  16 each  operands to the evaluator, registered
- pronto  in  1  evaluator done/idle level
- overflow  in  1  evaluator overflow, valid with `pronto`
- resultado  in  16  evaluator result, valid with `pronto`
- ocupado  out  1  sweep in progress
- fim  out  1  one-cycle pulse when the sweep ends
- erro  out  1  sticky timeout flag, cleared on the next accepted `comecar`
- dado_valido  out  1  FIFO not empty
- dado  out  33  FIFO head entry `{ovf, x[15:0], res[15:0]}`
- ler  in  1  pop the FIFO head; ignored when the FIFO is empty

Behaviour:
- Reset values: all outputs 0; FIFO emptied; FSM in OCIOSO. Reset applied mid-sweep aborts the sweep immediately, `inicio` drops to 0, and no `fim` pulse is produced.
- OCIOSO:
  - `comecar` latches the operands, clears `erro`, sets `ocupado`.
  - If `n_pontos` = 0, go to FIM.
  - Otherwise go to DISPARA.
  - `comecar` while `ocupado` = 1 is ignored.
- DISPARA:
  - If the FIFO count plus outstanding jobs equals PROF, stall here with `inicio` = 0.
  - Otherwise drive `inicio` = 1 for exactly one cycle, with X/A/B/C already stable, then go to AGUARDA_OCUPADO.
- AGUARDA_OCUPADO: wait for `pronto` = 0, so that a stale high `pronto` from the previous job is not taken as completion; then go to AGUARDA_PRONTO.
- AGUARDA_PRONTO: on `pronto` = 1, capture `{overflow, X, resultado}` and go to GRAVA.
- GRAVA:
  - Push the captured entry into the FIFO.
  - Update X to X + `passo` modulo 2^16; wrap-around is silent, no flag.
  - Decrement the remaining-point count.
  - If the count reaches 0, go to FIM; else go to DISPARA.
- FIM: assert `fim` for one cycle, clear `ocupado`, return to OCIOSO. The FIFO keeps its contents.
- Timeout: a counter runs in both wait states. When it reaches TIMEOUT:
  - set `erro`;
  - abandon the point, with no push;
  - go to FIM.
- Latency per point when `pronto` drops immediately after `inicio`: 1 (DISPARA) + evaluator time + 1 (GRAVA).
- FIFO rules:
  - Push and pop in the same cycle are both honoured, count unchanged.
  - Pop when empty is a no-op.
  - Push can never occur when full, because DISPARA stalls.
  - `dado` is the registered head entry and holds while `dado_valido` = 0.
- Evaluator operands X/A/B/C hold their value between jobs.

Optional Feature:
- Macro: PARA_OVERFLOW_EN.
- When defined:
  - an entry captured with `ovf` = 1 is still pushed;
  - the sweep then goes straight to FIM, skipping the remaining points;
  - `fim` pulses normally.
- When undefined: overflow is only recorded in the `ovf` bit of each entry and the sweep always runs all `n_pontos` points.

Decomposition:
- Shared package holds:
  - the state enum {OCIOSO, DISPARA, AGUARDA_OCUPADO, AGUARDA_PRONTO, GRAVA, FIM};
  - constants LARG_DADO = 16 and LARG_ENTRADA = 33;
  - field offsets of the entry.
- One sub-module, fifo_resultados:
  - synchronous FIFO parameterised by PROF and LARG_ENTRADA;
  - async active-low reset;
  - outputs: count, empty, full.

Test Plan (bench evaluator model computes A·X²+B·X+C):
- A=1, B=2, C=3, x_ini=0, passo=1, n_pontos=3 → FIFO holds entries (x,res) = (0,3), (1,6), (2,11), all with ovf=0; `fim` pulses once; `ocupado` falls in the same cycle.
- x_ini=0xFFFF, passo=1, n_pontos=2, A=0, B=1, C=0 → entry x values 0xFFFF then 0x0000; no error raised.
- n_pontos=10, PROF=8, `ler` held at 0 → exactly 8 `inicio` pulses; the FSM stalls in DISPARA; after 2 pops the remaining 2 jobs complete.
- Model never asserts `pronto` → `erro` = 1 after TIMEOUT cycles, `fim` pulses, FIFO remains empty; the next `comecar` clears `erro`.
- A=0x0100, x_ini=0x0100, n_pontos=4 with the model flagging overflow → PARA_OVERFLOW_EN defined: 1 entry then `fim`; undefined: 4 entries with ovf=1.
- `rst` asserted low during AGUARDA_PRONTO → `inicio`, `ocupado` and `dado_valido` all 0 immediately and no `fim`; a `comecar` after reset release starts a clean sweep.
